// File: rtl/eqed_pkg.sv
// Shared types and default widths for the EQED single-bit-flip injection controller.
package eqed_pkg;

    localparam int NUM_FF_DEF = 8;
    localparam int SEL_W_DEF  = $clog2(NUM_FF_DEF + 1);
    localparam int CNT_W_DEF  = 10;
    localparam int SIG_W_DEF  = 6;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        OBSERVE,
        CHECK,
        DONE
    } eqed_state_e;

endpackage

// File: rtl/eqed_inject_ctrl_if.sv
// Control/status bundle between the campaign sequencer and the EQED harness.
interface eqed_inject_ctrl_if
    import eqed_pkg::*;
#(
    parameter int NUM_FF = NUM_FF_DEF,
    parameter int SEL_W  = $clog2(NUM_FF + 1),
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SIG_W  = SIG_W_DEF
);
    logic              start;
    logic [SEL_W-1:0]  ff_idx;
    logic [CNT_W-1:0]  inject_cyc;
    logic [CNT_W-1:0]  obs_len;
    logic [SIG_W-1:0]  sig_obs;
    logic [SIG_W-1:0]  sig_gold;
    logic [NUM_FF-1:0] eqed_sel;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic              error_injected;
    logic              detected;
    logic [CNT_W-1:0]  cycle_count;
    logic [NUM_FF-1:0] detect_vec;

    modport master (
        output start, ff_idx, inject_cyc, obs_len, sig_obs, sig_gold,
        input  eqed_sel, dut_rst, busy, done, error_injected, detected,
               cycle_count, detect_vec
    );

    modport slave (
        input  start, ff_idx, inject_cyc, obs_len, sig_obs, sig_gold,
        output eqed_sel, dut_rst, busy, done, error_injected, detected,
               cycle_count, detect_vec
    );
endinterface

// File: rtl/eqed_onehot_dec.sv
// Index-to-one-hot decoder for the flip select; out-of-range index or !en gives all zeros.
module eqed_onehot_dec #(
    parameter int NUM_FF = 8,
    parameter int SEL_W  = $clog2(NUM_FF + 1)
) (
    input  logic [SEL_W-1:0]  idx,
    input  logic              en,
    output logic [NUM_FF-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_FF; i++) begin
            onehot[i] = en && (idx == SEL_W'(i));
        end
    end
endmodule

// File: rtl/eqed_inject_ctrl.sv
// EQED campaign sequencer: DUT reset, timed single-bit flip, observe window, signature check.
// Build option EQED_AUTO_SWEEP_EN: sweep all FF indices back to back and fill detect_vec.
//
// state   | meaning
// IDLE    | waiting for start, inputs latched on accept
// DUT_RST | one-cycle synchronous reset of DUT and MISRs
// RUN     | counting up to the injection cycle, flip applied on hit
// OBSERVE | letting the fault propagate for obs_len cycles
// CHECK   | compare observed MISR signature to golden
// DONE    | one-cycle completion pulse
module eqed_inject_ctrl
    import eqed_pkg::*;
#(
    parameter int NUM_FF = NUM_FF_DEF,
    parameter int SEL_W  = $clog2(NUM_FF + 1),
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SIG_W  = SIG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    eqed_inject_ctrl_if.slave   bus
);
    eqed_state_e       state_q, state_d;
    logic [SEL_W-1:0]  idx_q;
    logic [CNT_W-1:0]  eff_inj_q;
    logic [CNT_W-1:0]  obs_len_q;
    logic [CNT_W-1:0]  obs_cnt_q;
    logic [CNT_W-1:0]  cycle_count_q, count_d, count_inc;
    logic [NUM_FF-1:0] eqed_sel_q, sel_onehot;
    logic              sel_en;
    logic              error_injected_q;
    logic              detected_q;
    logic              sig_mismatch;

    assign count_inc    = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    assign sig_mismatch = (bus.sig_obs != bus.sig_gold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        count_d = cycle_count_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DUT_RST;
            DUT_RST: begin
                state_d = RUN;
                count_d = CNT_W'(1);
            end
            RUN: begin
                count_d = count_inc;
                if (cycle_count_q == eff_inj_q) state_d = OBSERVE;
            end
            OBSERVE: begin
                count_d = count_inc;
                if (obs_cnt_q <= CNT_W'(1)) state_d = CHECK;
            end
            CHECK: begin
                count_d = count_inc;
`ifdef EQED_AUTO_SWEEP_EN
                state_d = (idx_q == SEL_W'(NUM_FF - 1)) ? DONE : DUT_RST;
`else
                state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Look one cycle ahead so eqed_sel is a flop that lines up with cycle_count==eff_inj.
        sel_en = (state_d == RUN) && (count_d == eff_inj_q);
    end

    eqed_onehot_dec #(.NUM_FF(NUM_FF), .SEL_W(SEL_W)) u_dec (
        .idx    (idx_q),
        .en     (sel_en),
        .onehot (sel_onehot)
    );

`ifdef EQED_AUTO_SWEEP_EN
    localparam int IDX_W = $clog2(NUM_FF);
    logic [NUM_FF-1:0] detect_vec_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q            <= '0;
            eff_inj_q        <= CNT_W'(1);
            obs_len_q        <= '0;
            obs_cnt_q        <= '0;
            cycle_count_q    <= CNT_W'(1);
            eqed_sel_q       <= '0;
            error_injected_q <= 1'b0;
            detected_q       <= 1'b0;
`ifdef EQED_AUTO_SWEEP_EN
            detect_vec_q     <= '0;
`endif
        end else begin
            cycle_count_q    <= count_d;
            eqed_sel_q       <= sel_onehot;
            error_injected_q <= error_injected_q | (|eqed_sel_q);
            case (state_q)
                IDLE: if (bus.start) begin
`ifdef EQED_AUTO_SWEEP_EN
                    idx_q        <= '0;
                    detect_vec_q <= '0;
`else
                    idx_q        <= bus.ff_idx;
`endif
                    eff_inj_q        <= (bus.inject_cyc == '0) ? CNT_W'(1) : bus.inject_cyc;
                    obs_len_q        <= bus.obs_len;
                    detected_q       <= 1'b0;
                    error_injected_q <= 1'b0;
                end
                DUT_RST: error_injected_q <= 1'b0;
                RUN:     obs_cnt_q <= obs_len_q;
                OBSERVE: if (obs_cnt_q != '0) obs_cnt_q <= obs_cnt_q - CNT_W'(1);
                CHECK: begin
                    detected_q <= sig_mismatch;
`ifdef EQED_AUTO_SWEEP_EN
                    detect_vec_q[idx_q[IDX_W-1:0]] <= sig_mismatch;
                    idx_q <= idx_q + SEL_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.eqed_sel       = eqed_sel_q;
    assign bus.dut_rst        = (state_q == DUT_RST);
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = (state_q == DONE);
    assign bus.error_injected = error_injected_q;
    assign bus.detected       = detected_q;
    assign bus.cycle_count    = cycle_count_q;
`ifdef EQED_AUTO_SWEEP_EN
    assign bus.detect_vec     = detect_vec_q;
`else
    assign bus.detect_vec     = '0;
`endif
endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Scoreboard bench for eqed_inject_ctrl: directed runs push expectations, a monitor checks flips and done.
module tb_eqed_inject_ctrl;
    import eqed_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rst_at = 0;
    bit   prev_sel = 1'b0;

    typedef struct { logic [7:0] sel; int cnt; } sel_exp_t;
    typedef struct { logic err; logic det; logic [7:0] dvec; int lat; } res_exp_t;
    sel_exp_t sel_q[$];
    res_exp_t res_q[$];
    sel_exp_t se;
    res_exp_t re;

    eqed_inject_ctrl_if #(.NUM_FF(8), .SEL_W(4), .CNT_W(10), .SIG_W(6)) bus ();

    eqed_inject_ctrl #(.NUM_FF(8), .SEL_W(4), .CNT_W(10), .SIG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_sel(input logic [7:0] s, input int c);
        sel_exp_t e;
        e.sel = s; e.cnt = c;
        sel_q.push_back(e);
    endtask

    task automatic push_res(input logic err, input logic det, input logic [7:0] dv, input int lat);
        res_exp_t e;
        e.err = err; e.det = det; e.dvec = dv; e.lat = lat;
        res_q.push_back(e);
    endtask

    task automatic set_inputs(input logic [3:0] idx, input logic [9:0] inj, input logic [9:0] obs,
                              input logic [5:0] so, input logic [5:0] sg);
        bus.ff_idx = idx; bus.inject_cyc = inj; bus.obs_len = obs;
        bus.sig_obs = so; bus.sig_gold = sg;
    endtask

    task automatic launch(input logic [3:0] idx, input logic [9:0] inj, input logic [9:0] obs,
                          input logic [5:0] so, input logic [5:0] sg);
        @(posedge clk); #1;
        set_inputs(idx, inj, obs, so, sg);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Monitor: flips and completions are compared against the queues as they appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_sel) chk("err_inj_after_flip", 32'(bus.error_injected), 32'd1);
            prev_sel = |bus.eqed_sel;
            if (bus.dut_rst) begin
                rst_at = cyc;
`ifndef EQED_AUTO_SWEEP_EN
                chk("dut_rst_err_clear", 32'(bus.error_injected), 32'd0);
                chk("dut_rst_det_clear", 32'(bus.detected), 32'd0);
`endif
            end
            if (|bus.eqed_sel) begin
                chk("sel_onehot", 32'($onehot(bus.eqed_sel)), 32'd1);
                if (sel_q.size() == 0) begin
                    chk("unexpected_sel", 32'(bus.eqed_sel), 32'd0);
                end else begin
                    se = sel_q.pop_front();
                    chk("sel_value", 32'(bus.eqed_sel), 32'(se.sel));
                    chk("sel_cycle", 32'(bus.cycle_count), 32'(se.cnt));
                end
            end
            if (bus.done) begin
                chk("done_busy", 32'(bus.busy), 32'd1);
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    re = res_q.pop_front();
                    chk("res_err_inj", 32'(bus.error_injected), 32'(re.err));
                    chk("res_detected", 32'(bus.detected), 32'(re.det));
                    chk("res_detect_vec", 32'(bus.detect_vec), 32'(re.dvec));
                    chk("res_latency", 32'(cyc - rst_at), 32'(re.lat));
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        set_inputs(4'd0, 10'd0, 10'd0, 6'd0, 6'd0);
        repeat (3) @(negedge clk);
        chk("rst_eqed_sel", 32'(bus.eqed_sel), 32'd0);
        chk("rst_dut_rst", 32'(bus.dut_rst), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err_inj", 32'(bus.error_injected), 32'd0);
        chk("rst_detected", 32'(bus.detected), 32'd0);
        chk("rst_cycle_count", 32'(bus.cycle_count), 32'd1);
        chk("rst_detect_vec", 32'(bus.detect_vec), 32'd0);
        rst = 1'b0;

`ifdef EQED_AUTO_SWEEP_EN
        for (int r = 0; r < 8; r++) push_sel(8'(1 << r), 2);
        push_res(1'b1, 1'b0, 8'b0010_0100, 5);
        launch(4'd3, 10'd2, 10'd1, 6'h2B, 6'h2B);
        for (int r = 0; r < 8; r++) begin
            int n = 0;
            while (!bus.dut_rst && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus.dut_rst) chk("sweep_dut_rst_timeout", 32'(bus.dut_rst), 32'd1);
            bus.sig_obs = (r == 2 || r == 5) ? 6'h2A : 6'h2B;
            @(negedge clk);
        end
        wait_done(100);
        repeat (60) @(negedge clk);
`else
        // Single run: flip FF3 at cycle 4, observe 5
        push_sel(8'h08, 4);
        push_res(1'b1, 1'b0, 8'h00, 11);
        launch(4'd3, 10'd4, 10'd5, 6'h15, 6'h15);
        wait_done(50);

        // Golden run
        push_res(1'b0, 1'b0, 8'h00, 10);
        launch(4'd8, 10'd6, 10'd2, 6'h15, 6'h15);
        wait_done(50);

        // Detection, held until the next accepted start
        push_sel(8'h02, 2);
        push_res(1'b1, 1'b1, 8'h00, 7);
        launch(4'd1, 10'd2, 10'd3, 6'b111010, 6'b110010);
        wait_done(50);
        repeat (5) @(negedge clk);
        chk("detected_held", 32'(bus.detected), 32'd1);

        // inject_cyc=0, obs_len=0, start held across two runs
        push_sel(8'h80, 1);
        push_res(1'b1, 1'b0, 8'h00, 4);
        push_sel(8'h80, 1);
        push_res(1'b1, 1'b0, 8'h00, 4);
        @(posedge clk); #1;
        set_inputs(4'd7, 10'd0, 10'd0, 6'h0F, 6'h0F);
        bus.start = 1'b1;
        wait_done(50);
        @(negedge clk);
        chk("held_start_idle_gap", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("held_start_restart", 32'(bus.dut_rst), 32'd1);
        bus.start = 1'b0;
        wait_done(50);

        // Counter top: flip at cycle 1023
        push_sel(8'h01, 1023);
        push_res(1'b1, 1'b0, 8'h00, 1026);
        launch(4'd0, 10'd1023, 10'd1, 6'h01, 6'h01);
        wait_done(1100);

        // Abort during OBSERVE
        push_sel(8'h10, 3);
        launch(4'd4, 10'd3, 10'd20, 6'h05, 6'h05);
        repeat (6) @(posedge clk);
        #2;
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_eqed_sel", 32'(bus.eqed_sel), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_err_inj", 32'(bus.error_injected), 32'd0);
        chk("abort_cycle_count", 32'(bus.cycle_count), 32'd1);
        chk("abort_dut_rst", 32'(bus.dut_rst), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        push_sel(8'h08, 4);
        push_res(1'b1, 1'b0, 8'h00, 11);
        launch(4'd3, 10'd4, 10'd5, 6'h15, 6'h15);
        wait_done(50);
        repeat (20) @(negedge clk);
`endif
        chk("sel_queue_drained", 32'(sel_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
